// File: rtl/adc_seed_pool_gen.sv
// ---------------------------------------------------------------------------
// adc_seed_pool_gen: ADC-entropy pool feeding seed1/seed2 over valid/ready.
// Optional macro SEED_HEALTH_EN adds repetition / all-zero health tests. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
module adc_seed_pool_gen #(
  parameter int                SEED_W      = 128,
  parameter int                SAMPLE_W    = 16,
  parameter int                NUM_SAMPLES = 8,
  parameter int                LOOP_W      = 256,
  parameter logic [SEED_W-1:0] ADC_INIT    = 128'h3F72C91E5A6BD4FA8937CE1204B1DA6E,
  parameter logic [SEED_W-1:0] MASK1       = 128'hA8B2F3C01D9E6A3774CCE0B83F91AD24,
  parameter logic [SEED_W-1:0] MASK2       = 128'h6E1A9D2B44A7F80C2C913E5B7D34AC10,
  parameter int                REP_LIMIT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LOOP_W-1:0] seedloop,
  input  logic              reseed_req,
  input  logic              seed_ready,
  output logic              seed_valid,
  output logic [SEED_W-1:0] seed1,
  output logic [SEED_W-1:0] seed2,
  output logic [7:0]        sample_cnt,
  output logic              health_fail
);

  localparam logic [7:0] LAST_CNT = 8'(NUM_SAMPLES - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [SEED_W-1:0] adc_sample, adc_next;
  logic [SEED_W-1:0] pool, pool_nxt, pool_abs;
  logic [SEED_W-1:0] seed1_nxt, seed2_nxt;
  logic [7:0]        cnt_nxt;
  logic              valid_nxt;
  logic              last_absorb;
  logic              zero_trip;
  logic              health_trip;

  assign adc_next    = adc_sample ^ (adc_sample >> 1) ^ (adc_sample << 3) ^ seedloop[SEED_W-1:0];
  assign pool_abs    = (pool << SAMPLE_W) ^ adc_sample;
  assign last_absorb = (state == COLLECT) && (sample_cnt == LAST_CNT);

  generate
    if (LOOP_W > SEED_W) begin : g_loop_unused
      logic unused_loop_bits;
      assign unused_loop_bits = ^seedloop[LOOP_W-1:SEED_W];
    end
  endgenerate

`ifdef SEED_HEALTH_EN
  localparam int REP_W = $clog2(REP_LIMIT + 1);

  logic [REP_W-1:0] rep_cnt, rep_nxt;
  logic             rep_trip;

  // A stuck source trips once the run of unchanged samples reaches REP_LIMIT.
  assign rep_trip    = (adc_next == adc_sample) && (rep_cnt == REP_W'(REP_LIMIT - 1));
  assign zero_trip   = last_absorb && (pool_abs == '0);
  assign health_trip = rep_trip || zero_trip;
  assign rep_nxt     = ((adc_next != adc_sample) || rep_trip) ? '0 : rep_cnt + REP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt     <= '0;
      health_fail <= 1'b0;
    end else begin
      rep_cnt     <= rep_nxt;
      health_fail <= health_trip;
    end
  end
`else
  localparam int unused_rep_limit = REP_LIMIT;

  assign zero_trip   = 1'b0;
  assign health_trip = 1'b0;
  assign health_fail = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COLLECT;
      adc_sample <= ADC_INIT;
      pool       <= '0;
      sample_cnt <= 8'd0;
      seed_valid <= 1'b0;
      seed1      <= '0;
      seed2      <= '0;
    end else begin
      state      <= state_nxt;
      adc_sample <= adc_next;
      pool       <= pool_nxt;
      sample_cnt <= cnt_nxt;
      seed_valid <= valid_nxt;
      seed1      <= seed1_nxt;
      seed2      <= seed2_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pool_nxt  = pool;
    cnt_nxt   = sample_cnt;
    valid_nxt = seed_valid;
    seed1_nxt = seed1;
    seed2_nxt = seed2;

    case (state)
      COLLECT: begin
        pool_nxt = pool_abs;
        cnt_nxt  = sample_cnt + 8'd1;
        if (last_absorb && !zero_trip) begin
          seed1_nxt = pool_abs ^ MASK1;
          seed2_nxt = ~pool_abs ^ MASK2;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end
      end
      PRESENT: begin
        if (seed_ready) begin
          pool_nxt  = '0;
          cnt_nxt   = 8'd0;
          valid_nxt = 1'b0;
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase

    // Discards win over both completion and handshake; seeds stay stale but invalid.
    if (reseed_req || health_trip) begin
      pool_nxt  = '0;
      cnt_nxt   = 8'd0;
      valid_nxt = 1'b0;
      state_nxt = COLLECT;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_seed_pool_gen.sv
// Testbench for adc_seed_pool_gen: scoreboard against a sample-list reference model.
`default_nettype none
module tb_adc_seed_pool_gen;

  localparam int          W         = 128;
  localparam int          SW        = 16;
  localparam int          N         = 8;
  localparam int          REP_LIMIT = 4;
  localparam logic [127:0] ADC_INIT = 128'h3F72C91E5A6BD4FA8937CE1204B1DA6E;
  localparam logic [127:0] MASK1    = 128'hA8B2F3C01D9E6A3774CCE0B83F91AD24;
  localparam logic [127:0] MASK2    = 128'h6E1A9D2B44A7F80C2C913E5B7D34AC10;
  localparam logic [63:0]  ADC_INIT2 = 64'h8937CE1204B1DA6E;
  localparam logic [63:0]  MASK1_2   = 64'h74CCE0B83F91AD24;
  localparam logic [63:0]  MASK2_2   = 64'h2C913E5B7D34AC10;
  localparam logic [255:0] LOOP2 =
    256'h123456789ABCDEF0FEDCBA98765432100F1E2D3C4B5A69788796A5B4C3D2E1F0;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] seedloop = '0;
  logic         reseed_req = 1'b0;
  logic         seed_ready = 1'b1;
  logic         seed_valid, health_fail;
  logic [127:0] seed1, seed2;
  logic [7:0]   sample_cnt;
  logic         v2, hf2;
  logic [63:0]  s1_2, s2_2;
  logic [7:0]   cnt2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adc_seed_pool_gen dut (
    .clk(clk), .rst_n(rst_n), .seedloop(seedloop), .reseed_req(reseed_req),
    .seed_ready(seed_ready), .seed_valid(seed_valid), .seed1(seed1), .seed2(seed2),
    .sample_cnt(sample_cnt), .health_fail(health_fail)
  );

  adc_seed_pool_gen #(
    .SEED_W(64), .SAMPLE_W(8), .NUM_SAMPLES(4), .LOOP_W(256),
    .ADC_INIT(ADC_INIT2), .MASK1(MASK1_2), .MASK2(MASK2_2), .REP_LIMIT(REP_LIMIT)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .seedloop(LOOP2), .reseed_req(1'b0),
    .seed_ready(1'b1), .seed_valid(v2), .seed1(s1_2), .seed2(s2_2),
    .sample_cnt(cnt2), .health_fail(hf2)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] wmask(input int w);
    logic [127:0] m;
    m = (w >= 128) ? '1 : ((128'd1 << w) - 128'd1);
    return m;
  endfunction

  function automatic logic [127:0] adc_step(input logic [127:0] a, input logic [127:0] sl, input int w);
    return (a ^ (a >> 1) ^ (a << 3) ^ sl) & wmask(w);
  endfunction

  // Pool value = XOR of each sample shifted by SAMPLE_W per later sample.
  function automatic logic [127:0] fold(input logic [127:0] s[$], input int sw, input int w);
    logic [127:0] pf;
    pf = '0;
    for (int i = 0; i < s.size(); i++) pf ^= s[i] << (sw * (s.size() - 1 - i));
    return pf & wmask(w);
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed { logic [127:0] s1; logic [127:0] s2; } seed_t;
  seed_t        exp_q[$];
  logic [127:0] m_adc = ADC_INIT;
  logic [127:0] m_samp[$];
  bit           m_pres = 1'b0;
  bit           m_fail = 1'b0;
  int           m_cnt = 0;
  int           m_rep = 0;

  task automatic model_step();
    logic [127:0] cur, nxt, pf;
    cur    = m_adc;
    nxt    = adc_step(cur, seedloop[127:0], W);
    m_fail = 1'b0;
`ifdef SEED_HEALTH_EN
    m_rep = (nxt == cur) ? m_rep + 1 : 0;
    if (m_rep == REP_LIMIT) begin
      m_fail = 1'b1;
      m_rep  = 0;
    end
`endif
    if (!m_pres) begin
      m_samp.push_back(cur);
      if (m_samp.size() == N) begin
        pf = fold(m_samp, SW, W);
`ifdef SEED_HEALTH_EN
        if (pf == '0) m_fail = 1'b1;
`endif
        if (!reseed_req && !m_fail) begin
          exp_q.push_back('{s1: pf ^ MASK1, s2: ~pf ^ MASK2});
          m_pres = 1'b1;
        end
      end
    end else if (seed_ready) begin
      m_pres = 1'b0;
      m_samp.delete();
    end
    if (reseed_req || m_fail) begin
      m_pres = 1'b0;
      m_samp.delete();
    end
    m_cnt = m_pres ? N : m_samp.size();
    m_adc = nxt;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_adc = ADC_INIT; m_samp.delete(); exp_q.delete();
        m_pres = 1'b0; m_fail = 1'b0; m_cnt = 0; m_rep = 0;
      end else begin
        model_step();
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    seed_t cur_exp;
    bit    prev_v = 1'b0;
    bit    have = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("valid", 128'(seed_valid), 128'(m_pres));
        chk("sample_cnt", 128'(sample_cnt), 128'(m_cnt));
        chk("health_fail", 128'(health_fail), 128'(m_fail));
        if (seed_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL seed_unexpected: got valid with no expected seed at %0t", $time);
            have = 1'b0;
          end else begin
            cur_exp = exp_q.pop_front();
            have = 1'b1;
          end
        end
        if (seed_valid && have) begin
          chk("seed1", seed1, cur_exp.s1);
          chk("seed2", seed2, cur_exp.s2);
        end
        prev_v = seed_valid;
      end else begin
        prev_v = 1'b0;
        have   = 1'b0;
      end
    end
  end

  // ---------------- narrow configuration ----------------
  initial begin
    logic [127:0] a[$];
    logic [127:0] q[$];
    logic [127:0] ai, pf;
    ai = 128'(ADC_INIT2);
    for (int i = 0; i < 12; i++) begin
      a.push_back(ai);
      ai = adc_step(ai, LOOP2[127:0], 64);
    end
    @(posedge rst_n);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 3 || k == 5) chk("w64_valid_low", 128'(v2), 128'd0);
      if (k == 4 || k == 9) begin
        q.delete();
        for (int j = 0; j < 4; j++) q.push_back(a[(k == 4) ? j : 5 + j]);
        pf = fold(q, 8, 64);
        chk("w64_valid", 128'(v2), 128'd1);
        chk("w64_seed1", 128'(s1_2), (pf ^ 128'(MASK1_2)) & wmask(64));
        chk("w64_seed2", 128'(s2_2), (~pf ^ 128'(MASK2_2)) & wmask(64));
      end
    end
    chk("w64_health", 128'(hf2), 128'd0);
  end

  task automatic wait_valid(output int k, input int lim);
    k = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      if (seed_valid) begin
        k = i;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_valid", 128'(seed_valid), 128'd0);
    chk("rst_seed1", seed1, 128'd0);
    chk("rst_seed2", seed2, 128'd0);
    chk("rst_cnt", 128'(sample_cnt), 128'd0);
    chk("rst_health", 128'(health_fail), 128'd0);
    rst_n = 1'b1;

    wait_valid(k, 20);
    chk("first_latency", 128'(k), 128'(N));
    @(negedge clk);
    wait_valid(k, 20);
    chk("back_to_back", 128'(k + 1), 128'(N + 1));

    seed_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("stall_valid", 128'(seed_valid), 128'd1);
    chk("stall_cnt", 128'(sample_cnt), 128'(N));
    seed_ready = 1'b1;
    @(negedge clk);
    chk("accept_valid", 128'(seed_valid), 128'd0);
    chk("accept_cnt", 128'(sample_cnt), 128'd0);

    k = -1;
    for (int i = 0; i < 20; i++) begin
      if (sample_cnt == 8'd5) begin k = i; break; end
      @(negedge clk);
    end
    chk("reach_cnt5", 128'(k >= 0), 128'd1);
    reseed_req = 1'b1;
    seed_ready = 1'b0;
    @(negedge clk);
    reseed_req = 1'b0;
    chk("reseed_cnt", 128'(sample_cnt), 128'd0);
    wait_valid(k, 20);
    chk("reseed_latency", 128'(k), 128'(N));

    repeat (2) @(negedge clk);
    seed_ready = 1'b1;
    reseed_req = 1'b1;
    @(negedge clk);
    reseed_req = 1'b0;
    chk("reseed_present_valid", 128'(seed_valid), 128'd0);
    chk("reseed_present_cnt", 128'(sample_cnt), 128'd0);
    wait_valid(k, 20);
    chk("fresh_latency", 128'(k), 128'(N));

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      seedloop   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      seed_ready = ($urandom_range(3) != 0);
      reseed_req = ($urandom_range(31) == 0);
    end
    @(negedge clk);
    reseed_req = 1'b0;
    seed_ready = 1'b1;

`ifdef SEED_HEALTH_EN
    begin
      int pulses, at, vseen;
      reseed_req = 1'b1;
      @(negedge clk);
      reseed_req = 1'b0;
      pulses = 0; at = -1; vseen = 0;
      for (int i = 1; i <= 6; i++) begin
        seedloop = {128'd0, (m_adc >> 1) ^ (m_adc << 3)};
        @(negedge clk);
        if (health_fail) begin
          pulses++;
          at = i;
          chk("health_discard_cnt", 128'(sample_cnt), 128'd0);
        end
        if (seed_valid) vseen++;
      end
      chk("health_pulses", 128'(pulses), 128'd1);
      chk("health_cycle", 128'(at), 128'(REP_LIMIT));
      chk("health_no_valid", 128'(vseen), 128'd0);
      seedloop = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    end
`endif

    repeat (30) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/adc_seed_pool_gen.md
Name: adc_seed_pool_gen

Overview:
Parametrised successor to the 128-bit ADC seed generator. It runs a simulated ADC entropy source mixed with the NLFSR loop value, and accumulates NUM_SAMPLES samples into an entropy pool. It delivers seed1/seed2 pairs through a valid/ready handshake and supports synchronous reseed. It sits between the NLFSR core and the SHA-256 conditioner.

Parameters:
SEED_W, 128, width of adc_sample, the pool, seed1 and seed2.
SAMPLE_W, 16, pool shift per absorbed sample (1..SEED_W-1).
NUM_SAMPLES, 8, samples absorbed per seed (2..255).
LOOP_W, 256, seedloop width (must be >= SEED_W).
ADC_INIT, 128'h3F72C91E5A6BD4FA8937CE1204B1DA6E, adc_sample reset value.
MASK1, 128'hA8B2F3C01D9E6A3774CCE0B83F91AD24, seed1 whitening mask.
MASK2, 128'h6E1A9D2B44A7F80C2C913E5B7D34AC10, seed2 whitening mask.
REP_LIMIT, 4, consecutive identical samples that count as a health failure (used only with the optional feature).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
seedloop  in  LOOP_W  NLFSR state; bits [SEED_W-1:0] are mixed in
reseed_req  in  1  synchronous pulse: discard the pool and restart collection
seed_ready  in  1  consumer accepts the seed
seed_valid  out  1  seed1/seed2 hold a complete seed
seed1  out  SEED_W  pool_final ^ MASK1
seed2  out  SEED_W  ~pool_final ^ MASK2
sample_cnt  out  8  samples absorbed into the current pool
health_fail  out  1  one-cycle pulse on a health-test failure (0 when the feature is off)

Behaviour:
- Reset (rst_n low, asynchronous): adc_sample = ADC_INIT, pool = 0, sample_cnt = 0, state = COLLECT, seed_valid = 0, seed1 = 0, seed2 = 0, health_fail = 0.
- ADC source is free-running every cycle, in all states: adc_sample <= adc_sample ^ (adc_sample >> 1) ^ (adc_sample << 3) ^ seedloop[SEED_W-1:0]. Shifts are truncated to SEED_W bits.
- States: COLLECT and PRESENT.
- COLLECT, each cycle:
  - pool <= (pool << SAMPLE_W) ^ adc_sample, using the current registered adc_sample.
  - sample_cnt increments.
  - On the cycle with sample_cnt == NUM_SAMPLES-1, the absorbed value is pool_final. Then seed1 <= pool_final ^ MASK1, seed2 <= ~pool_final ^ MASK2, seed_valid <= 1, state <= PRESENT, and sample_cnt holds NUM_SAMPLES.
- Latency: seed_valid first rises NUM_SAMPLES cycles after reset deassertion.
- PRESENT:
  - pool, seed1 and seed2 are frozen. seed_valid stays 1 until seed_valid & seed_ready.
  - On the handshake cycle: next cycle seed_valid = 0, pool = 0, sample_cnt = 0, state = COLLECT.
  - No seed is lost or duplicated. Back-to-back seeds are NUM_SAMPLES+1 cycles apart when seed_ready is held high.
- seed_ready while in COLLECT is ignored.
- reseed_req, in any state, has priority over the handshake and over seed completion. Next cycle: pool = 0, sample_cnt = 0, seed_valid = 0, state = COLLECT. seed1/seed2 keep their stale values but are invalid. adc_sample is unaffected.
- All arithmetic is modulo 2^SEED_W. sample_cnt is 8 bits, so NUM_SAMPLES <= 255 and no wrap occurs.

Optional Feature:
SEED_HEALTH_EN
- Defined: a repetition counter tracks consecutive cycles where the next adc_sample equals the current one; any change resets the count. When the count reaches REP_LIMIT:
  - health_fail pulses for 1 cycle.
  - The current pool is discarded exactly as for reseed_req, including a discard in PRESENT with valid dropped.
  - The counter clears.
  - An all-zero pool_final also triggers health_fail plus a discard instead of presenting a seed.
- Not defined: no counter logic; health_fail is tied to 0.

Test Plan:
1. Reset, defaults, seedloop = 0, seed_ready = 1 -> seed_valid rises on cycle 8 after rst_n release; seed1/seed2 match the bench model (ADC_INIT, 8 absorbs, masks); next seed follows 9 cycles later.
2. seed_ready = 0 for 20 cycles after valid -> seed_valid, seed1, seed2 and sample_cnt = 8 are stable; one cycle after seed_ready = 1, seed_valid = 0 and sample_cnt = 0.
3. reseed_req at sample_cnt = 5 -> next cycle sample_cnt = 0; valid arrives 8 cycles later with the model value computed from the restarted pool.
4. reseed_req and seed_ready together in PRESENT -> seed_valid = 0, pool cleared, the following seed matches the fresh-pool model.
5. Rerun with SEED_W = 64, SAMPLE_W = 8, NUM_SAMPLES = 4 and seedloop = 256'h1234... -> valid on cycle 4 and values match the model truncated to 64 bits.
6. With SEED_HEALTH_EN, bench drives seedloop = f(adc_sample) ^ adc_sample so the sample is stuck -> health_fail pulses 4 cycles later, sample_cnt = 0 next cycle, no seed_valid is issued during the stuck interval.
